memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between an instruction cache and a data
// cache. The data side normally has priority. A grant lasts until the RAM
// reports ACCESS or until the granted side drops its request. Outputs are
// decoded from the state register and the current inputs.
//
// Optional build macro STARVE_GUARD_EN adds a 4-bit starvation counter. After
// STARVE_LIMIT consecutive data grants with an instruction request waiting,
// the next arbitration goes to the instruction side.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    // instruction cache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // data cache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DGRANT = 2'd1;
    localparam logic [1:0] IGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    // Limits outside 1..15 cannot be represented by the 4-bit counter; such a
    // configuration elaborates this empty marker block and is easy to spot.
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_starve_limit_out_of_range
    end

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic       d_req_s;
    logic       ram_access_s;
    logic       starve_s;

    assign d_req_s      = dREN | dWEN;
    assign ram_access_s = (ramstate == RAM_ACCESS);

`ifdef STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_r;

    // Count data grants issued while an instruction request waits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt_r <= 4'd0;
        end else if (!iREN) begin
            starve_cnt_r <= 4'd0;
        end else if ((state_r == IDLE) && (state_next_s == IGRANT)) begin
            starve_cnt_r <= 4'd0;
        end else if ((state_r == IDLE) && (state_next_s == DGRANT) &&
                     (starve_cnt_r != 4'hF)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign starve_s = iREN & (starve_cnt_r == STARVE_LIMIT_C);
`else
    assign starve_s = 1'b0;
`endif

    // Arbitration and grant release.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (starve_s) begin
                    state_next_s = IGRANT;
                end else if (d_req_s) begin
                    state_next_s = DGRANT;
                end else if (iREN) begin
                    state_next_s = IGRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DGRANT: begin
                if (!d_req_s || ram_access_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DGRANT;
                end
            end
            IGRANT: begin
                if (!iREN || ram_access_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = IGRANT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register. Reset returns to IDLE at once, dropping any grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Route the granted side to the RAM and return the completion to it.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        case (state_r)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (d_req_s && ram_access_s) begin
                    dwait = 1'b0;
                    dload = ramload;
                end else begin
                    dwait = 1'b1;
                    dload = 32'd0;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iREN && ram_access_s) begin
                    iwait = 1'b0;
                    iload = ramload;
                end else begin
                    iwait = 1'b1;
                    iload = 32'd0;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule
